// File: rtl/apb_timer_slave.sv
// APB timer peripheral: prescaled up-counter compared against an auto-reload value,
// with a sticky match flag and a level interrupt. Every transfer takes two wait states.
//
// state | meaning
// IDLE  | no transfer in progress, waiting for the first ACCESS cycle
// WAIT  | single wait state; read data is sampled on leaving it
// RESP  | PREADY high for this cycle; a write commits at its closing edge
module apb_timer_slave #(
   parameter int CNT_W = 32,
   parameter int PSC_W = 16
) (
   input  logic        PCLK,
   input  logic        PRESETn,
   input  logic        PSEL,
   input  logic        PENABLE,
   input  logic        PWRITE,
   input  logic [31:0] PADDR,
   input  logic [31:0] PWDATA,
   output logic [31:0] PRDATA,
   output logic        PREADY,
   output logic        irq
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } bus_state_t;

   localparam logic [9:0] IDX_CTRL   = 10'd0;
   localparam logic [9:0] IDX_PSC    = 10'd1;
   localparam logic [9:0] IDX_ARR    = 10'd2;
   localparam logic [9:0] IDX_CNT    = 10'd3;
   localparam logic [9:0] IDX_STATUS = 10'd4;

   bus_state_t       state;
   logic             ctrl_en, ctrl_auto, ctrl_ie;
   logic [PSC_W-1:0] psc, psc_cnt;
   logic [CNT_W-1:0] arr, cnt;
   logic             match;
   logic [9:0]       reg_idx;
   logic             access, wr_commit;
   logic             wr_ctrl, wr_psc, wr_arr, wr_cnt, wr_status;
   logic             tick, hit, en_next;
   logic [31:0]      rd_mux;
   logic             unused_paddr;

   assign reg_idx      = PADDR[11:2];
   assign unused_paddr = ^{PADDR[31:12], PADDR[1:0]};
   assign access       = PSEL & PENABLE;
   assign wr_commit    = (state == ST_RESP) & access & PWRITE;
   assign wr_ctrl      = wr_commit & (reg_idx == IDX_CTRL);
   assign wr_psc       = wr_commit & (reg_idx == IDX_PSC);
   assign wr_arr       = wr_commit & (reg_idx == IDX_ARR);
   assign wr_cnt       = wr_commit & (reg_idx == IDX_CNT);
   assign wr_status    = wr_commit & (reg_idx == IDX_STATUS);

   // A CTRL write that stops the timer swallows a tick landing on the same edge.
   assign tick = ctrl_en & (psc_cnt == psc) & ~(wr_ctrl & ~PWDATA[0]);
   assign hit  = tick & (cnt == arr);

   always_comb begin
      en_next = ctrl_en;
      if (wr_ctrl)
         en_next = PWDATA[0];
      else if (hit & ~ctrl_auto)
         en_next = 1'b0;
   end

   always_comb begin
      rd_mux = '0;
      case (reg_idx)
         IDX_CTRL:   rd_mux[2:0] = {ctrl_ie, ctrl_auto, ctrl_en};
         IDX_PSC:    rd_mux[PSC_W-1:0] = psc;
         IDX_ARR:    rd_mux[CNT_W-1:0] = arr;
         IDX_CNT:    rd_mux[CNT_W-1:0] = cnt;
         IDX_STATUS: rd_mux[0] = match;
         default:    rd_mux = '0;
      endcase
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state  <= ST_IDLE;
         PREADY <= 1'b0;
         PRDATA <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               PREADY <= 1'b0;
               PRDATA <= '0;
               if (access)
                  state <= ST_WAIT;
            end
            ST_WAIT: begin
               if (access) begin
                  state  <= ST_RESP;
                  PREADY <= 1'b1;
                  PRDATA <= PWRITE ? 32'd0 : rd_mux;
               end else begin
                  state <= ST_IDLE;
               end
            end
            ST_RESP: begin
               state  <= ST_IDLE;
               PREADY <= 1'b0;
               PRDATA <= '0;
            end
            default: begin
               state  <= ST_IDLE;
               PREADY <= 1'b0;
               PRDATA <= '0;
            end
         endcase
      end
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         ctrl_en   <= 1'b0;
         ctrl_auto <= 1'b0;
         ctrl_ie   <= 1'b0;
         psc       <= '0;
         arr       <= '0;
         cnt       <= '0;
         match     <= 1'b0;
         psc_cnt   <= '0;
         irq       <= 1'b0;
      end else begin
         ctrl_en <= en_next;
         if (wr_ctrl) begin
            ctrl_auto <= PWDATA[1];
            ctrl_ie   <= PWDATA[2];
         end
         if (wr_psc)
            psc <= PWDATA[PSC_W-1:0];
         if (wr_arr)
            arr <= PWDATA[CNT_W-1:0];

         // Prescaler restarts from zero whenever the timer is (re)started or PSC changes.
         if (wr_psc || !en_next || !ctrl_en || (psc_cnt == psc))
            psc_cnt <= '0;
         else
            psc_cnt <= psc_cnt + PSC_W'(1);

         if (wr_cnt)
            cnt <= PWDATA[CNT_W-1:0];
         else if (hit)
            cnt <= '0;
         else if (tick)
            cnt <= cnt + CNT_W'(1);

         if (hit)
            match <= 1'b1;
         else if (wr_status && PWDATA[0])
            match <= 1'b0;

         irq <= match & ctrl_ie;
      end
   end

endmodule

// File: tb/tb_apb_timer_slave.sv
// Bench for apb_timer_slave: directed scenarios with literal expectations, then random
// APB traffic checked every cycle against a register-level reference model.
module tb_apb_timer_slave;

   logic        PCLK = 1'b0;
   logic        PRESETn;
   logic        PSEL, PENABLE, PWRITE;
   logic [31:0] PADDR, PWDATA;
   logic [31:0] PRDATA;
   logic        PREADY;
   logic        irq;

   int n_checks = 0;
   int n_fail   = 0;

   apb_timer_slave #(.CNT_W(32), .PSC_W(16)) dut (
      .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
      .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .irq(irq)
   );

   always #5 PCLK = ~PCLK;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic        m_en, m_auto, m_ie, m_match, m_irq;
   logic [15:0] m_psc, m_pc;
   logic [31:0] m_arr, m_cnt;
   int          acc;
   logic        exp_ready;
   logic [31:0] exp_rdata;

   function automatic logic [31:0] m_read(input logic [9:0] idx);
      case (idx)
         10'd0:   return {29'd0, m_ie, m_auto, m_en};
         10'd1:   return {16'd0, m_psc};
         10'd2:   return m_arr;
         10'd3:   return m_cnt;
         10'd4:   return {31'd0, m_match};
         default: return 32'd0;
      endcase
   endfunction

   always @(posedge PCLK or negedge PRESETn) begin : model
      logic        sel, commit, stop_wr, tk, hit, en_nx;
      logic [9:0]  idx;
      logic [31:0] rd_now;
      if (!PRESETn) begin
         m_en <= 0; m_auto <= 0; m_ie <= 0; m_match <= 0; m_irq <= 0;
         m_psc <= 0; m_pc <= 0; m_arr <= 0; m_cnt <= 0;
         acc <= 0; exp_ready <= 0; exp_rdata <= 0;
      end else begin
         sel     = PSEL && PENABLE;
         idx     = PADDR[11:2];
         commit  = exp_ready && sel && PWRITE;
         rd_now  = m_read(idx);
         stop_wr = commit && idx == 10'd0 && !PWDATA[0];
         tk      = m_en && (m_pc == m_psc) && !stop_wr;
         hit     = tk && (m_cnt == m_arr);
         if (commit && idx == 10'd0) en_nx = PWDATA[0];
         else if (hit && !m_auto)    en_nx = 1'b0;
         else                        en_nx = m_en;

         m_en <= en_nx;
         if (commit && idx == 10'd0) begin m_auto <= PWDATA[1]; m_ie <= PWDATA[2]; end
         if (commit && idx == 10'd1) m_psc <= PWDATA[15:0];
         if (commit && idx == 10'd2) m_arr <= PWDATA;
         if ((commit && idx == 10'd1) || !en_nx || !m_en || m_pc == m_psc) m_pc <= 0;
         else m_pc <= m_pc + 16'd1;

         if (commit && idx == 10'd3) m_cnt <= PWDATA;
         else if (hit)               m_cnt <= 0;
         else if (tk)                m_cnt <= m_cnt + 32'd1;

         if (hit) m_match <= 1;
         else if (commit && idx == 10'd4 && PWDATA[0]) m_match <= 0;
         m_irq <= m_match && m_ie;

         // Response appears in the third consecutive ACCESS cycle.
         if (exp_ready && sel) begin
            acc <= 0; exp_ready <= 0; exp_rdata <= 0;
         end else if (sel) begin
            acc <= acc + 1;
            exp_ready <= (acc + 1 == 2);
            exp_rdata <= (acc + 1 == 2 && !PWRITE) ? rd_now : 32'd0;
         end else begin
            acc <= 0; exp_ready <= 0; exp_rdata <= 0;
         end
      end
   end

   always @(negedge PCLK) begin
      check("pready", {31'd0, PREADY}, {31'd0, exp_ready});
      check("prdata", PRDATA, exp_rdata);
      check("irq", {31'd0, irq}, {31'd0, m_irq});
   end

   // ---------------- bus tasks (entered and left at a falling edge) ----------------
   task automatic xfer(input logic w, input logic [31:0] addr, input logic [31:0] wdata,
                       output logic [31:0] rdata);
      int lat;
      PSEL = 1; PENABLE = 0; PWRITE = w; PADDR = addr; PWDATA = wdata;
      @(negedge PCLK);
      PENABLE = 1;
      lat = 1;
      while (lat < 8) begin
         @(negedge PCLK);
         lat++;
         if (PREADY) break;
      end
      check("ready_latency", lat, 3);
      rdata = PRDATA;
      @(negedge PCLK);
      PSEL = 0; PENABLE = 0;
   endtask

   task automatic apb_wr(input logic [31:0] addr, input logic [31:0] data);
      logic [31:0] d;
      xfer(1'b1, addr, data, d);
   endtask

   task automatic apb_rd_check(input string name, input logic [31:0] addr, input logic [31:0] exp);
      logic [31:0] d;
      xfer(1'b0, addr, $urandom, d);
      check(name, d, exp);
   endtask

   task automatic apb_abort(input logic [31:0] addr);
      PSEL = 1; PENABLE = 0; PWRITE = 1; PADDR = addr; PWDATA = $urandom;
      @(negedge PCLK);
      PENABLE = 1;
      @(negedge PCLK);
      PSEL = 0; PENABLE = 0;
   endtask

   localparam logic [31:0] BASE = 32'h1000_3000;

   initial begin
      logic [31:0] d;
      int k;
      PRESETn = 0; PSEL = 0; PENABLE = 0; PWRITE = 0; PADDR = 0; PWDATA = 0;
      repeat (3) @(negedge PCLK);
      PRESETn = 1;
      @(negedge PCLK);

      // reset values and unmapped offset
      for (int i = 0; i < 5; i++) apb_rd_check("reset_read", BASE + 32'(i * 4), 32'd0);
      apb_rd_check("unmapped_read", BASE + 32'h20, 32'd0);

      // bus timing on an ARR write
      apb_wr(BASE + 32'h08, 32'h64);
      check("ready_width", {31'd0, PREADY}, 32'd0);
      apb_rd_check("arr_readback", BASE + 32'h08, 32'h64);

      // periodic: tick every 4 cycles, match every 20
      apb_wr(BASE + 32'h04, 32'd3);
      apb_wr(BASE + 32'h08, 32'd4);
      apb_wr(BASE + 32'h00, 32'h7);
      fork
         begin
            apb_rd_check("cnt_seq0", BASE + 32'h0C, 32'd0);
            apb_rd_check("cnt_seq1", BASE + 32'h0C, 32'd1);
            apb_rd_check("cnt_seq2", BASE + 32'h0C, 32'd2);
            apb_rd_check("cnt_seq3", BASE + 32'h0C, 32'd3);
            apb_rd_check("cnt_seq4", BASE + 32'h0C, 32'd4);
            apb_rd_check("cnt_seq5", BASE + 32'h0C, 32'd0);
         end
         begin
            k = 0;
            while (!irq && k < 100) begin @(negedge PCLK); k++; end
            check("irq_delay", k, 21);
         end
      join

      // async reset in the middle of a transfer
      PSEL = 1; PENABLE = 0; PWRITE = 1; PADDR = BASE; PWDATA = 32'h0;
      @(negedge PCLK); PENABLE = 1;
      @(negedge PCLK);
      @(negedge PCLK);
      check("pre_reset_ready", {31'd0, PREADY}, 32'd1);
      check("pre_reset_irq", {31'd0, irq}, 32'd1);
      #2 PRESETn = 0;
      #1;
      check("reset_ready", {31'd0, PREADY}, 32'd0);
      check("reset_irq", {31'd0, irq}, 32'd0);
      @(negedge PCLK); PSEL = 0; PENABLE = 0;
      @(negedge PCLK); PRESETn = 1;
      @(negedge PCLK);
      for (int i = 0; i < 5; i++) apb_rd_check("post_reset_read", BASE + 32'(i * 4), 32'd0);

      // one-shot
      apb_wr(BASE + 32'h08, 32'd2);
      apb_wr(BASE + 32'h00, 32'h5);
      repeat (4) @(negedge PCLK);
      check("oneshot_model_cnt", m_cnt, 32'd0);
      check("oneshot_model_en", {31'd0, m_en}, 32'd0);
      apb_rd_check("oneshot_ctrl", BASE + 32'h00, 32'h4);
      apb_rd_check("oneshot_cnt", BASE + 32'h0C, 32'd0);
      apb_rd_check("oneshot_status", BASE + 32'h10, 32'd1);
      check("oneshot_irq", {31'd0, irq}, 32'd1);

      // W1C clear landing on a match tick, then a stopping CTRL write on a tick
      apb_wr(BASE + 32'h10, 32'h1);
      apb_wr(BASE + 32'h08, 32'd3);
      apb_wr(BASE + 32'h00, 32'h7);
      apb_wr(BASE + 32'h10, 32'h1);
      apb_rd_check("w1c_race_status", BASE + 32'h10, 32'd1);
      apb_wr(BASE + 32'h00, 32'h4);
      apb_wr(BASE + 32'h10, 32'h1);
      check("w1c_irq_hold", {31'd0, irq}, 32'd1);
      @(negedge PCLK);
      check("w1c_irq_drop", {31'd0, irq}, 32'd0);
      apb_rd_check("stop_discards_tick", BASE + 32'h0C, 32'd3);

      // CNT write on a tick edge wins
      apb_wr(BASE + 32'h04, 32'd3);
      apb_wr(BASE + 32'h08, 32'hFF);
      apb_wr(BASE + 32'h00, 32'h3);
      apb_wr(BASE + 32'h0C, 32'h10);
      apb_rd_check("cnt_write_wins", BASE + 32'h0C, 32'h10);
      apb_rd_check("cnt_after_tick", BASE + 32'h0C, 32'h11);

      // ARR below CNT: counter wraps through zero before matching
      apb_wr(BASE + 32'h00, 32'h0);
      apb_wr(BASE + 32'h10, 32'h1);
      apb_wr(BASE + 32'h04, 32'd0);
      apb_wr(BASE + 32'h08, 32'd1);
      apb_wr(BASE + 32'h0C, 32'hFFFF_FFFE);
      apb_wr(BASE + 32'h00, 32'h1);
      apb_rd_check("wrap_cnt", BASE + 32'h0C, 32'd0);
      apb_rd_check("wrap_status", BASE + 32'h10, 32'd1);
      apb_rd_check("wrap_cnt_final", BASE + 32'h0C, 32'd0);

      // random traffic, checked cycle by cycle against the model
      for (int n = 0; n < 400; n++) begin
         int unsigned op, r;
         logic [9:0]  idx;
         logic [31:0] data, addr;
         op = $urandom_range(0, 9);
         r  = $urandom_range(0, 6);
         idx = (r < 5) ? 10'(r) : 10'($urandom_range(5, 1023));
         case (r)
            0:       data = $urandom;
            1:       data = ($urandom & 32'hFFFF_0000) | $urandom_range(0, 3);
            2:       data = $urandom_range(0, 6);
            3:       data = $urandom_range(0, 8);
            4:       data = ($urandom & 32'hFFFF_FFFE) | $urandom_range(0, 1);
            default: data = $urandom;
         endcase
         addr = {20'h10003, idx, 2'($urandom_range(0, 3))};
         if (op <= 4)      apb_wr(addr, data);
         else if (op <= 8) xfer(1'b0, addr, data, d);
         else              apb_abort(addr);
         repeat ($urandom_range(0, 2)) @(negedge PCLK);
      end

      repeat (4) @(negedge PCLK);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
